fetch_pair: RTL and testbench
=============================

Name: fetch_pair

Overview:
- Dual-issue fetch stage directly upstream of Schedule.
- Holds the PC and reads one aligned 64-bit word (two instructions) per cycle from a synchronous instruction memory.
- Packs each word with its PCs into the 128-bit fetch_data bundle Schedule consumes: {instr2, pc2, instr1, pc1}.
- Takes the jal redirect back from Schedule and the branch redirect from execute; kills wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, filler for slot 2 on a misaligned fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  32  byte address, bits [2:0] always 0
- imem_rdata  in  64  {word at addr+4, word at addr}; valid the cycle after the request
- fetch_data  out  128  {instr2, pc2, instr1, pc1}, to Schedule
- fetch_valid  out  1  fetch_data holds a live pair
- fetch_ready  in  1  Schedule accepts the pair this cycle
- jal  in  1  redirect from Schedule
- jal_addr  in  32  jal target
- br_redirect  in  1  mispredict redirect from execute
- br_addr  in  32  branch target

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC.
  - imem_req=0, imem_addr=0.
  - fetch_valid=0, fetch_data=0.
  - Skid buffer empty; in-flight flag cleared.
- Pipeline, three cycles from PC to output:
  - F1 (cycle N): imem_addr={pc_q[31:3],3'b000}; imem_req=1 unless held.
  - F2 (cycle N+1): imem_rdata present; req_pc_q tags it.
  - OUT (cycle N+2): registered fetch_data/fetch_valid.
- Aligned pack (req_pc[2]=0):
  - instr1=rdata[31:0], pc1=req_pc.
  - instr2=rdata[63:32], pc2=req_pc+4.
  - next pc=pc+8.
- Misaligned pack (req_pc[2]=1):
  - instr1=rdata[63:32], pc1=req_pc.
  - instr2=NOP_INSTR, pc2=req_pc+4.
  - next pc=pc+4, i.e. realigns.
- PC adds wrap modulo 2^32.
- Handshake:
  - A pair transfers when fetch_valid && fetch_ready.
  - While fetch_valid && !fetch_ready: fetch_data is held stable and imem_req=0.
  - A response already in flight is written to the one-entry skid buffer.
  - On fetch_ready, the skid buffer drains into OUT before any new response.
  - A request is issued only if OUT or the skid buffer will have room for its response.
- Redirect, sampled at edge N:
  - br_redirect has priority over jal. If both are asserted, br_addr wins.
  - pc_q takes the target.
  - fetch_valid clears and the skid buffer empties at the same edge.
  - The response in flight in N+1 is discarded (kill flag).
  - imem_addr shows the target in N+1; the target pair reaches fetch_valid in N+3.
  - A redirect in the same cycle as a stall still flushes. The held pair is dropped even though fetch_ready=0.
  - Back-to-back redirects: the last one wins, and each one kills everything older.
- rst_n deasserted mid-operation: the next request issues at RESET_PC in the first cycle after release. Nothing in flight survives.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_stall (32 bits), both reset to 0 by rst_n.
  - perf_fetched adds 2 per accepted aligned pair and 1 per accepted misaligned pair.
  - perf_stall adds 1 per cycle with fetch_valid && !fetch_ready.
  - Both counters wrap.
- Undefined: the ports and counter logic are absent. Fetch behaviour is identical either way.

Test Plan:
- Reset then release, fetch_ready=1, imem word 0 = {32'h0001E237, 32'h00014137}:
  - imem_addr=0 on the first cycle after release.
  - fetch_data=128'h0001E237_00000004_00014137_00000000 with fetch_valid=1 two cycles later.
- Sequential streaming, fetch_ready=1:
  - imem_addr sequence 0x0, 0x8, 0x10, 0x18.
  - One valid pair per cycle, with pc1 stepping by 8.
- jal=1, jal_addr=0x104 at cycle N:
  - Wrong-path response killed.
  - imem_addr=0x100 in N+1.
  - In N+3: pc1=0x104, instr1=rdata[63:32], instr2=32'h00000013, pc2=0x108.
  - Next imem_addr=0x108.
- fetch_ready=0 for 4 cycles while streaming:
  - fetch_data held constant.
  - imem_req=0 after the skid buffer fills.
  - On release, the held pair and then the skid pair are delivered in order, with no loss or duplication.
- br_redirect (br_addr=0x200) and jal (jal_addr=0x300) asserted together during a stall:
  - Held pair dropped.
  - imem_addr=0x200; the 0x300 target is never fetched.
- Redirect to 0xFFFFFFF8: pair pcs 0xFFFFFFF8 and 0xFFFFFFFC; next imem_addr=0x0 (wrap).
  - With FETCH_PERF_EN defined, perf_fetched and perf_stall match the counts driven by the bench.

Source files
------------

// File: rtl/fetch_pair.sv
// Dual-issue fetch stage: PC -> synchronous imem read -> packed {instr2,pc2,instr1,pc1} pair.
// Optional perf counters are compiled in with `define FETCH_PERF_EN.
module fetch_pair #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic [63:0]  imem_rdata,
  output logic [127:0] fetch_data,
  output logic         fetch_valid,
  input  logic         fetch_ready,
  input  logic         jal,
  input  logic [31:0]  jal_addr,
  input  logic         br_redirect,
  input  logic [31:0]  br_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);

  logic [31:0]  pc_p0;
  logic [31:0]  req_pc_p1;
  logic         vld_p1;
  logic         kill_p1;
  logic [127:0] data_p2;
  logic         vld_p2;
  logic [127:0] skid_data_p2;
  logic         skid_vld_p2;

  logic         stall;
  logic         redirect;
  logic [31:0]  target;
  logic         issue;
  logic         resp_ok;
  logic         out_free;
  logic [31:0]  pc_step;
  logic [127:0] resp_pair;

  function automatic logic [127:0] pack_pair(input logic [63:0] rdata, input logic [31:0] pc);
    logic [31:0] instr1;
    logic [31:0] instr2;
    instr1 = pc[2] ? rdata[63:32] : rdata[31:0];
    instr2 = pc[2] ? NOP_INSTR : rdata[63:32];
    return {instr2, pc + 32'd4, instr1, pc};
  endfunction

  assign stall     = vld_p2 && !fetch_ready;
  assign redirect  = br_redirect || jal;
  assign target    = br_redirect ? br_addr : jal_addr;
  assign out_free  = !vld_p2 || fetch_ready;
  // Holding off while the skid entry is occupied guarantees every response has a landing slot.
  assign issue     = rst_n && !stall && !skid_vld_p2;
  assign pc_step   = pc_p0[2] ? 32'd4 : 32'd8;
  assign resp_ok   = vld_p1 && !kill_p1 && !redirect;
  assign resp_pair = pack_pair(imem_rdata, req_pc_p1);

  // F1: request the aligned word holding pc_p0
  assign imem_req  = issue;
  assign imem_addr = rst_n ? {pc_p0[31:3], 3'b000} : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0       <= RESET_PC;
      vld_p1      <= 1'b0;
      kill_p1     <= 1'b0;
      vld_p2      <= 1'b0;
      skid_vld_p2 <= 1'b0;
      data_p2     <= '0;
    end else begin
      vld_p1  <= issue;
      kill_p1 <= redirect;
      if (redirect) begin
        pc_p0 <= target;
      end else if (issue) begin
        pc_p0 <= pc_p0 + pc_step;
      end
      // OUT: the skid entry always drains ahead of a fresh response
      if (redirect) begin
        vld_p2      <= 1'b0;
        skid_vld_p2 <= 1'b0;
      end else if (out_free) begin
        if (skid_vld_p2) begin
          data_p2     <= skid_data_p2;
          vld_p2      <= 1'b1;
          skid_vld_p2 <= resp_ok;
        end else begin
          vld_p2 <= resp_ok;
          if (resp_ok) begin
            data_p2 <= resp_pair;
          end
        end
      end else if (resp_ok) begin
        skid_vld_p2 <= 1'b1;
      end
    end
  end

  // F2: tag the returning word with the PC that requested it
  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc_p1 <= pc_p0;
    end
    if (resp_ok) begin
      skid_data_p2 <= resp_pair;
    end
  end

  assign fetch_data  = data_p2;
  assign fetch_valid = vld_p2;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (vld_p2 && fetch_ready) begin
        perf_fetched <= perf_fetched + (data_p2[2] ? 32'd1 : 32'd2);
      end
      if (stall) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pair.sv
// Randomized bench for fetch_pair against a stream-level model of the expected pair sequence.
module tb_fetch_pair;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [63:0]  imem_rdata;
  logic [127:0] fetch_data;
  logic         fetch_valid;
  logic         fetch_ready;
  logic         jal;
  logic [31:0]  jal_addr;
  logic         br_redirect;
  logic [31:0]  br_addr;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetched;
  logic [31:0]  perf_stall;
`endif

  fetch_pair dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .jal(jal), .jal_addr(jal_addr), .br_redirect(br_redirect), .br_addr(br_addr)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;
  logic [31:0] req_exp;
  logic [31:0] tgt;
  int          since;
  int          ready_run;
  bit          first_pending;
  bit          mem_pend;
  logic [31:0] mem_addr;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;

  // Instruction memory contents: instruction stored at each word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0001_4137;
    if (a == 32'd4) return 32'h0001_E237;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    return p[2] ? p + 32'd4 : p + 32'd8;
  endfunction

  function automatic logic [127:0] exp_pair(input logic [31:0] p);
    logic [31:0] i2;
    i2 = p[2] ? NOP : mem_word(p + 32'd4);
    return {i2, p + 32'd4, mem_word(p), p};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    exp_pc    = 32'd0;
    req_exp   = 32'd0;
    tgt       = 32'd0;
    since     = 1;
    ready_run = 0;
    mem_pend  = 1'b0;
    m_fetched = 32'd0;
    m_stall   = 32'd0;
  endtask

  // Called at posedge+1; holds rst_n low for n cycles, then releases it.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    fetch_ready = 1'b1; jal = 1'b0; br_redirect = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_valid", 128'(fetch_valid), 128'd0);
      chk("rst_data", fetch_data, 128'd0);
      chk("rst_req", 128'(imem_req), 128'd0);
      chk("rst_addr", 128'(imem_addr), 128'd0);
`ifdef FETCH_PERF_EN
      chk("rst_perf", {64'd0, perf_fetched, perf_stall}, 128'd0);
`endif
      @(posedge clk); #1;
      imem_rdata = {$urandom, $urandom};
    end
    reset_model();
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit rdy, input bit j, input logic [31:0] ja,
                       input bit b, input logic [31:0] ba);
    fetch_ready = rdy; jal = j; jal_addr = ja; br_redirect = b; br_addr = ba;
    @(negedge clk);
    ready_run = rdy ? ready_run + 1 : 0;
    if (since == 1 || since == 2) chk("flush_valid", 128'(fetch_valid), 128'd0);
    if (since == 1 || since == 2) chk("tgt_req", 128'(imem_req), 128'd1);
    if (since == 3) chk("tgt_valid", 128'(fetch_valid), 128'd1);
    if (since == 3 && first_pending) begin
      chk("first_pair", fetch_data, 128'h0001E237_00000004_00014137_00000000);
      first_pending = 1'b0;
    end
    if (since >= 3 && ready_run >= 4) chk("stream_valid", 128'(fetch_valid), 128'd1);
    if (fetch_valid) chk("pair", fetch_data, exp_pair(exp_pc));
    if (fetch_valid && !rdy) begin
      chk("stall_req", 128'(imem_req), 128'd0);
      m_stall++;
    end
    if (imem_req) begin
      chk("req_addr", 128'(imem_addr), 128'(req_exp & 32'hFFFF_FFF8));
      req_exp = next_pc(req_exp);
    end
    if (fetch_valid && rdy) begin
      m_fetched += exp_pc[2] ? 32'd1 : 32'd2;
      exp_pc = next_pc(exp_pc);
    end
    if (b || j) begin
      tgt     = b ? ba : ja;
      exp_pc  = tgt;
      req_exp = tgt;
      since   = 0;
    end
    if (since < 1000) since++;
    mem_pend = imem_req;
    mem_addr = imem_addr;
    @(posedge clk); #1;
    imem_rdata = mem_pend ? {mem_word(mem_addr + 32'd4), mem_word(mem_addr)} : {$urandom, $urandom};
  endtask

  task automatic run_ready(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic run_stall(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_ready = 1'b1; jal = 1'b0; jal_addr = 32'd0; br_redirect = 1'b0; br_addr = 32'd0;
    imem_rdata = 64'd0;
    first_pending = 1'b1;
    reset_model();
    @(posedge clk); #1;
    do_reset(3);

    // Streaming from reset, then a four-cycle backpressure window.
    run_ready(12);
    run_stall(4);
    run_ready(8);

    // jal to a misaligned target.
    cycle(1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'd0);
    run_ready(8);

    // Branch and jal together during a stall: branch wins, held pair dropped.
    run_stall(2);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0200);
    run_stall(1);
    run_ready(8);

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8);
    run_ready(6);

    // Back-to-back redirects.
    cycle(1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_2004);
    run_ready(6);

    // Randomized backpressure and redirects.
    for (int i = 0; i < 800; i++) begin
      bit          rdy, j, b;
      logic [31:0] ja, ba;
      rdy = ($urandom_range(0, 3) != 0);
      j   = ($urandom_range(0, 24) == 0);
      b   = ($urandom_range(0, 24) == 0);
      ja  = $urandom & 32'hFFFF_FFFC;
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                        : ($urandom & 32'hFFFF_FFFC);
      cycle(rdy, j, ja, b, ba);
    end

`ifdef FETCH_PERF_EN
    chk("perf_fetched", 128'(perf_fetched), 128'(m_fetched));
    chk("perf_stall", 128'(perf_stall), 128'(m_stall));
`endif

    // Reset asserted mid-operation, then more random traffic.
    do_reset(2);
    for (int i = 0; i < 40; i++) cycle($urandom_range(0, 3) != 0, 1'b0, 32'd0, 1'b0, 32'd0);

`ifdef FETCH_PERF_EN
    chk("perf_fetched_end", 128'(perf_fetched), 128'(m_fetched));
    chk("perf_stall_end", 128'(perf_stall), 128'(m_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
